// File: rtl/input_capture.sv
// Purpose: synchronise and debounce a push-button and capture the switch word on each accepted press.
// Latency: a press or release is accepted DEBOUNCE_CYCLES+1 edges after btn_raw first samples the new level.
// Backpressure: none; data_valid is a one-cycle pulse and the consumer must take data_out in that cycle.
module input_capture #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [3:0] sw_in,
    output logic       btn_level,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       sel
);

    // A 1-bit counter still covers the smallest legal window (2 samples).
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic             btn_s1;
    logic             btn_s2;
    logic [3:0]       sw_s1;
    logic [3:0]       sw_s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             accept;

    // Two-flop synchronisers for the button and every switch bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= 4'b0000;
            sw_s2  <= 4'b0000;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
        end
    end

    // State, counter and registered outputs; the capture and sel toggle only happen on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            btn_level  <= 1'b0;
            data_out   <= 4'b0000;
            data_valid <= 1'b0;
            sel        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            btn_level  <= level_nxt;
            data_valid <= accept;
            if (accept) begin
                data_out <= sw_s2;
                sel      <= ~sel;
            end
        end
    end

    // Debounce FSM: each wait state counts consecutive samples of the new level and aborts on any reversal.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = btn_level;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_input_capture.sv
// Purpose: randomised and directed stimulus for input_capture, checked against a run-length reference model.
// Latency: expected pulses are scheduled two edges after the raw run completes (synchroniser delay).
// Backpressure: none; the monitor checks every cycle and every data_valid pulse.
module tb_input_capture;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic [3:0] sw_in = 4'h0;
    logic       btn_level;
    logic [3:0] data_out;
    logic       data_valid;
    logic       sel;

    input_capture #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .sw_in      (sw_in),
        .btn_level  (btn_level),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sel        (sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       lvl;
        logic [3:0] data;
    } ev_t;

    typedef struct {
        int         e;
        logic [3:0] d;
        logic       s;
    } exp_t;

    // Reference model state: visible outputs plus the raw-run tracker.
    ev_t        pend[$];
    exp_t       sb[$];
    int         edge_n = 0;
    logic       m_level = 1'b0;
    logic       m_sel = 1'b0;
    logic [3:0] m_data = 4'h0;
    logic       target = 1'b0;
    int         run = 0;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pulses = 0;

    // Model one clock edge: a level change is accepted once N consecutive raw samples disagree
    // with the last accepted level, and it becomes visible two edges later.
    task automatic model_edge(input logic r, input logic b, input logic [3:0] sw);
        ev_t ev;
        edge_n++;
        if (r) begin
            m_level = 1'b0;
            m_sel   = 1'b0;
            m_data  = 4'h0;
            target  = 1'b0;
            run     = 0;
            pend.delete();
        end else begin
            while (pend.size() > 0 && pend[0].due == edge_n) begin
                ev = pend.pop_front();
                m_level = ev.lvl;
                if (ev.lvl) begin
                    m_sel  = ~m_sel;
                    m_data = ev.data;
                    sb.push_back('{e: edge_n, d: m_data, s: m_sel});
                    n_pulses++;
                end
            end
            if (b != target) begin
                run++;
                if (run == N) begin
                    target = b;
                    run    = 0;
                    pend.push_back('{due: edge_n + 2, lvl: b, data: sw});
                end
            end else begin
                run = 0;
            end
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, update the model just after the rising edge.
    task automatic cyc(input logic r, input logic b, input logic [3:0] sw);
        @(negedge clk);
        rst     = r;
        btn_raw = b;
        sw_in   = sw;
        @(posedge clk);
        #1;
        model_edge(r, b, sw);
    endtask

    task automatic hold(input logic b, input int n, input logic [3:0] sw);
        for (int i = 0; i < n; i++) cyc(1'b0, b, sw);
    endtask

    // Monitor: compare visible outputs every cycle and pop the scoreboard on each data_valid pulse.
    always @(negedge clk) begin
        exp_t x;
        if (chk_en) begin
            n_cmp++;
            if (btn_level !== m_level) begin
                n_err++;
                $display("FAIL btn_level edge %0d: got %b want %b", edge_n, btn_level, m_level);
            end
            n_cmp++;
            if (sel !== m_sel) begin
                n_err++;
                $display("FAIL sel edge %0d: got %b want %b", edge_n, sel, m_sel);
            end
            n_cmp++;
            if (data_out !== m_data) begin
                n_err++;
                $display("FAIL data_out edge %0d: got %h want %h", edge_n, data_out, m_data);
            end
            n_cmp++;
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse edge %0d: got data_valid=1 want 0", edge_n);
                end else begin
                    x = sb.pop_front();
                    if (x.e != edge_n || x.d !== data_out || x.s !== sel) begin
                        n_err++;
                        $display("FAIL pulse edge %0d: got data=%h sel=%b want edge %0d data=%h sel=%b",
                                 edge_n, data_out, sel, x.e, x.d, x.s);
                    end
                end
            end else if (data_valid !== 1'b0) begin
                n_err++;
                $display("FAIL data_valid edge %0d: got %b want 0/1", edge_n, data_valid);
            end else if (sb.size() > 0 && sb[0].e <= edge_n) begin
                x = sb.pop_front();
                n_err++;
                $display("FAIL missing_pulse edge %0d: got data_valid=0 want 1 at edge %0d", edge_n, x.e);
            end
        end
    end

    // Directed scenarios first, then randomised button activity with occasional resets.
    initial begin
        logic       b;
        logic [3:0] sw;
        int         pulses_before;

        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0);
        chk_en = 1'b1;
        hold(1'b0, 3, 4'h0);

        // Clean press with 1011, then clean release.
        hold(1'b1, 10, 4'b1011);
        hold(1'b0, 10, 4'b1011);

        // Bounce: 2 high, 1 low, 3 high, then low: nothing accepted.
        pulses_before = n_pulses;
        hold(1'b1, 2, 4'h6);
        hold(1'b0, 1, 4'h6);
        hold(1'b1, 3, 4'h6);
        hold(1'b0, 10, 4'h6);
        n_cmp++;
        if (n_pulses != pulses_before) begin
            n_err++;
            $display("FAIL bounce_model: got %0d pulses want 0", n_pulses - pulses_before);
        end

        // Two full cycles with 3 then C.
        hold(1'b1, 10, 4'h3);
        hold(1'b0, 10, 4'h3);
        hold(1'b1, 10, 4'hC);
        hold(1'b0, 10, 4'hC);

        // Release bounce: low 2 then high again, then a clean release.
        hold(1'b1, 10, 4'h9);
        hold(1'b0, 2, 4'h9);
        hold(1'b1, 6, 4'h9);
        hold(1'b0, 10, 4'h9);

        // Reset while in PRESS_WAIT with cnt=2 and the button held, then re-accept.
        hold(1'b1, 4, 4'hE);
        cyc(1'b1, 1'b1, 4'hE);
        hold(1'b1, 10, 4'hE);
        hold(1'b0, 10, 4'hE);

        // Switch change while held: data_out must stay at 5.
        hold(1'b1, 8, 4'h5);
        hold(1'b1, 8, 4'hA);
        hold(1'b0, 10, 4'hA);

        // Randomised phase.
        b  = 1'b0;
        sw = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 6) == 0) b = ~b;
            if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0, b, sw);
        end
        hold(1'b0, 12, 4'h0);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending pulses want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_capture.md
INPUT_CAPTURE -- requirements
Module: input_capture

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 270000, giving the number of consecutive stable synchronized samples required to accept a level change (10 ms at 27 MHz); legal range >= 2.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port btn_raw  input  1  asynchronous, bouncing push-button level, 1 = pressed.
REQ-005 SHALL provide port sw_in  input  4  asynchronous switch word, the data to be encoded.
REQ-006 SHALL provide port btn_level  output  1  debounced button level.
REQ-007 SHALL provide port data_out  output  4  switch word captured on the last accepted press.
REQ-008 SHALL provide port data_valid  output  1  one-cycle pulse marking a new data_out.
REQ-009 SHALL provide port sel  output  1  toggles on each accepted press; drives the display-select input (0 = corrected word, 1 = syndrome).

Function
REQ-010 SHALL pass btn_raw and each sw_in bit through a 2-flop synchronizer; s2 denotes the synchronized button.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a counter cnt sized ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-012 IDLE: s2=1 -> PRESS_WAIT with cnt=1; otherwise hold with cnt=0.
REQ-013 PRESS_WAIT: s2=0 -> IDLE with cnt=0 (bounce rejected, no output change); s2=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise cnt+1.
REQ-014 On the PRESS_WAIT->PRESSED edge: btn_level<=1, data_out<=synchronized sw_in, data_valid<=1, sel<=~sel, all on the same edge.
REQ-015 data_valid SHALL be high for exactly one cycle per accepted press and low in all other cycles.
REQ-016 PRESSED: s2=0 -> RELEASE_WAIT with cnt=1; otherwise hold with cnt=0.
REQ-017 RELEASE_WAIT: s2=1 -> PRESSED with cnt=0; s2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE with btn_level<=0; otherwise cnt+1.
REQ-018 Release SHALL NOT pulse data_valid, toggle sel or change data_out.
REQ-019 Latency: if edge k is the first of an unbroken high run of btn_raw, the acceptance edge SHALL be k+DEBOUNCE_CYCLES+1; release latency is symmetric.
REQ-020 A high run of btn_raw shorter than DEBOUNCE_CYCLES sampled edges SHALL produce no output change.
REQ-021 sw_in changes while btn_level=1 SHALL NOT affect data_out until the next accepted press.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-023 A button held continuously SHALL yield exactly one press, with no auto-repeat.

Reset
REQ-024 With rst=1 at an edge: state=IDLE, cnt=0, synchronizers=0, btn_level=0, data_out=4'b0000, data_valid=0, sel=0.
REQ-025 rst SHALL override all other inputs, including mid-PRESS_WAIT and the acceptance edge itself; no data_valid pulse is issued in a reset cycle.
REQ-026 If the button is held through reset release, it SHALL be debounced afresh and accepted as a new press per REQ-019.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Clean press: sw_in=4'b1011, btn_raw 0->1 first sampled at edge 0 and held -> data_valid=1 only after edge 5; data_out=4'b1011; sel=1; btn_level=1.
REQ-028 Bounce: btn_raw high for 2 edges, low 1, high 3, then low -> no data_valid; sel, data_out and btn_level unchanged.
REQ-029 Two full press/release cycles with sw_in=4'h3 then 4'hC -> data_out=4'h3 then 4'hC; sel 0->1->0; exactly two data_valid pulses.
REQ-030 Release bounce: while PRESSED, btn_raw low for 2 edges then high -> btn_level stays 1, no pulse; final clean release -> btn_level=0 at edge k+5.
REQ-031 Reset mid-operation: rst=1 for one edge while in PRESS_WAIT with cnt=2 and btn held -> all outputs at reset values; press re-accepted DEBOUNCE_CYCLES+1 edges after the first post-reset sample of 1.
REQ-032 Switch change while held: change sw_in 4'h5->4'hA after acceptance -> data_out remains 4'h5 and no extra data_valid pulse.
